// File: rtl/gat_bram_load_ctrl.sv
// gat_bram_load_ctrl
//
// Host-to-BRAM load controller for the GAT core input memories. Each of the
// NUM_CH channels takes byte-addressed 32-bit host writes and turns them into
// word-addressed BRAM writes, with the data truncated to CH_DATA_W bits. Each
// channel counts the words it accepts. When the host raises load done, that
// count is checked against a runtime expected count. Once every channel is
// loaded, the block issues a single gat_start pulse.
//
// Ports
//   clk, rst        : clock, synchronous active-high reset
//   clear           : one-cycle pulse that restarts loading for a new layer
//   host_din        : per-channel 32-bit write data, channel c at [c*TOP_WIDTH +: TOP_WIDTH]
//   host_ena/wea    : per-channel enable / write enable
//   host_addra      : per-channel byte address (CH_ADDR_W+2 bits)
//   host_load_done  : per-channel load-done level; its rising edge closes the channel
//   exp_cnt         : per-channel expected word count (CNT_W bits)
//   bram_din/addra  : registered write data / word address, held between writes
//   bram_ena/wea    : registered enables, high for exactly one cycle per accepted write
//   ch_loaded       : channel state (1 = DONE, 0 = LOADING); this is the FSM state bit
//   all_loaded      : every channel is DONE (registered one cycle after ch_loaded)
//   gat_start       : one-cycle pulse in the first cycle all_loaded is high
//   status          : {all_loaded, err_ovf[6:0], err_cnt, err_addr, ch_loaded}
//
// Handshake: there is no backpressure. A host write is accepted in the cycle
// in which ena & wea are high, the channel is LOADING, the address is
// word-aligned and clear is low. An accepted write shows up on the BRAM port
// exactly one cycle later.
module gat_bram_load_ctrl #(
  parameter int NUM_CH    = 3,
  parameter int TOP_WIDTH = 32,
  parameter int CH_DATA_W = 16,
  parameter int CH_ADDR_W = 18,
  parameter int CNT_W     = CH_ADDR_W + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [NUM_CH*TOP_WIDTH-1:0]    host_din,
  input  logic [NUM_CH-1:0]              host_ena,
  input  logic [NUM_CH-1:0]              host_wea,
  input  logic [NUM_CH*(CH_ADDR_W+2)-1:0] host_addra,
  input  logic [NUM_CH-1:0]              host_load_done,
  input  logic [NUM_CH*CNT_W-1:0]        exp_cnt,
  output logic [NUM_CH*CH_DATA_W-1:0]    bram_din,
  output logic [NUM_CH-1:0]              bram_ena,
  output logic [NUM_CH-1:0]              bram_wea,
  output logic [NUM_CH*CH_ADDR_W-1:0]    bram_addra,
  output logic [NUM_CH-1:0]              ch_loaded,
  output logic                           all_loaded,
  output logic                           gat_start,
  output logic [TOP_WIDTH-1:0]           status
);

  localparam int HA_W = CH_ADDR_W + 2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    LOADING = 1'b0,
    DONE    = 1'b1
  } ch_state_e;

  ch_state_e        state_q [NUM_CH];
  ch_state_e        state_d [NUM_CH];
  logic [CNT_W-1:0] cnt_q   [NUM_CH];
  logic [CNT_W-1:0] cnt_d   [NUM_CH];

  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] err_addr_q, err_addr_d;
  logic [NUM_CH-1:0] err_cnt_q, err_cnt_d;
  logic [NUM_CH-1:0] err_ovf_q, err_ovf_d;
  logic [NUM_CH-1:0] bram_en_q;
  logic              all_loaded_q, all_loaded_d;
  logic              gat_start_q, gat_start_d;

  // Only the low CH_DATA_W bits of each host word reach the BRAM.
  logic unused_din;
  assign unused_din = ^host_din;

  // Next-state logic, one independent FSM per channel.
  always_comb begin
    logic             wr;
    logic             aligned;
    logic             in_loading;
    logic             done_edge;
    logic [CNT_W-1:0] cnt_inc;

    accept     = '0;
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    err_ovf_d  = err_ovf_q;
    wr         = 1'b0;
    aligned    = 1'b0;
    in_loading = 1'b0;
    done_edge  = 1'b0;
    cnt_inc    = '0;

    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];

      wr         = host_ena[c] & host_wea[c];
      aligned    = (host_addra[c*HA_W +: 2] == 2'b00);
      in_loading = (state_q[c] == LOADING);
      done_edge  = host_load_done[c] & ~done_q[c];
      accept[c]  = wr & in_loading & aligned & ~clear;

      // The count checked on a done edge includes a write accepted in the
      // same cycle. The counter saturates instead of wrapping.
      cnt_inc = (accept[c] && (cnt_q[c] != CNT_MAX)) ? cnt_q[c] + CNT_ONE : cnt_q[c];

      if (clear) begin
        state_d[c]    = LOADING;
        cnt_d[c]      = '0;
        err_addr_d[c] = 1'b0;
        err_cnt_d[c]  = 1'b0;
        err_ovf_d[c]  = 1'b0;
      end else begin
        cnt_d[c] = cnt_inc;
        if (wr && in_loading && !aligned) err_addr_d[c] = 1'b1;
        if (wr && !in_loading)            err_ovf_d[c]  = 1'b1;
        if (done_edge && in_loading) begin
          state_d[c] = DONE;
          if (cnt_inc != exp_cnt[c*CNT_W +: CNT_W]) err_cnt_d[c] = 1'b1;
        end
      end
    end

    // all_loaded follows the registered ch_loaded, so it trails ch_loaded by one cycle.
    all_loaded_d = ~clear & (&ch_loaded);
    gat_start_d  = all_loaded_d & ~all_loaded_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= LOADING;
        cnt_q[c]   <= '0;
      end
      done_q       <= '0;
      err_addr_q   <= '0;
      err_cnt_q    <= '0;
      err_ovf_q    <= '0;
      bram_en_q    <= '0;
      bram_din     <= '0;
      bram_addra   <= '0;
      all_loaded_q <= 1'b0;
      gat_start_q  <= 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        if (accept[c]) begin
          bram_din[c*CH_DATA_W +: CH_DATA_W]   <= host_din[c*TOP_WIDTH +: CH_DATA_W];
          bram_addra[c*CH_ADDR_W +: CH_ADDR_W] <= host_addra[c*HA_W + 2 +: CH_ADDR_W];
        end
      end
      // done_q keeps tracking during clear so a level held across clear is not a new edge.
      done_q       <= host_load_done;
      err_addr_q   <= err_addr_d;
      err_cnt_q    <= err_cnt_d;
      err_ovf_q    <= err_ovf_d;
      bram_en_q    <= accept;
      all_loaded_q <= all_loaded_d;
      gat_start_q  <= gat_start_d;
    end
  end

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ch_loaded[c] = (state_q[c] == DONE);
    end
  end

  assign bram_ena   = bram_en_q;
  assign bram_wea   = bram_en_q;
  assign all_loaded = all_loaded_q;
  assign gat_start  = gat_start_q;

  always_comb begin
    logic [7:0] loaded8;
    logic [7:0] eaddr8;
    logic [7:0] ecnt8;
    logic [7:0] eovf8;
    loaded8 = '0;
    eaddr8  = '0;
    ecnt8   = '0;
    eovf8   = '0;
    loaded8[NUM_CH-1:0] = ch_loaded;
    eaddr8[NUM_CH-1:0]  = err_addr_q;
    ecnt8[NUM_CH-1:0]   = err_cnt_q;
    eovf8[NUM_CH-1:0]   = err_ovf_q;
    status = {all_loaded_q, eovf8[6:0], ecnt8, eaddr8, loaded8};
  end

endmodule

// File: tb/tb_gat_bram_load_ctrl.sv
// Directed testbench for gat_bram_load_ctrl (NUM_CH=3, CH_DATA_W=16, CH_ADDR_W=18).
module tb_gat_bram_load_ctrl;

  localparam int NCH = 3;
  localparam int TW  = 32;
  localparam int DW  = 16;
  localparam int AW  = 18;
  localparam int CW  = AW + 1;

  logic                  clk;
  logic                  rst;
  logic                  clear;
  logic [NCH*TW-1:0]     host_din;
  logic [NCH-1:0]        host_ena;
  logic [NCH-1:0]        host_wea;
  logic [NCH*(AW+2)-1:0] host_addra;
  logic [NCH-1:0]        host_load_done;
  logic [NCH*CW-1:0]     exp_cnt;
  logic [NCH*DW-1:0]     bram_din;
  logic [NCH-1:0]        bram_ena;
  logic [NCH-1:0]        bram_wea;
  logic [NCH*AW-1:0]     bram_addra;
  logic [NCH-1:0]        ch_loaded;
  logic                  all_loaded;
  logic                  gat_start;
  logic [TW-1:0]         status;

  int n_checks = 0;
  int n_fail   = 0;

  gat_bram_load_ctrl #(
    .NUM_CH(NCH), .TOP_WIDTH(TW), .CH_DATA_W(DW), .CH_ADDR_W(AW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .host_din(host_din), .host_ena(host_ena), .host_wea(host_wea),
    .host_addra(host_addra), .host_load_done(host_load_done), .exp_cnt(exp_cnt),
    .bram_din(bram_din), .bram_ena(bram_ena), .bram_wea(bram_wea),
    .bram_addra(bram_addra), .ch_loaded(ch_loaded), .all_loaded(all_loaded),
    .gat_start(gat_start), .status(status)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    host_ena = '0;
    host_wea = '0;
  endtask

  task automatic wr(input int c, input logic [AW+1:0] addr, input logic [31:0] data);
    host_ena[c] = 1'b1;
    host_wea[c] = 1'b1;
    host_addra[c*(AW+2) +: (AW+2)] = addr;
    host_din[c*TW +: TW] = data;
  endtask

  task automatic set_exp(input int c, input logic [CW-1:0] v);
    exp_cnt[c*CW +: CW] = v;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input int c);
    return 32'(bram_addra[c*AW +: AW]);
  endfunction

  function automatic logic [31:0] din_of(input int c);
    return 32'(bram_din[c*DW +: DW]);
  endfunction

  initial begin
    rst = 1'b1; clear = 1'b0;
    host_din = '0; host_ena = '0; host_wea = '0; host_addra = '0;
    host_load_done = '0; exp_cnt = '0;
    tick(); tick();

    // reset state
    check("rst_status", status, 32'h0);
    check("rst_ena", 32'(bram_ena), 32'h0);
    check("rst_wea", 32'(bram_wea), 32'h0);
    check("rst_addr", 32'(bram_addra), 32'h0);
    check("rst_din", 32'(bram_din), 32'h0);
    check("rst_start", 32'(gat_start), 32'h0);
    rst = 1'b0;

    // ---- normal load: ch0 4 words, ch1 2 words, ch2 3 words ----
    set_exp(0, 19'd4); set_exp(1, 19'd2); set_exp(2, 19'd3);
    for (int k = 0; k < 4; k++) begin
      idle();
      wr(0, 20'(4*k), 32'h1000 + 32'(k));
      if (k < 2) wr(1, 20'(4*k), 32'h2000 + 32'(k));
      if (k < 3) wr(2, 20'(4*k), 32'h3000 + 32'(k));
      tick();
      check($sformatf("ld_ena_%0d", k), 32'(bram_ena),
            (k < 2) ? 32'h7 : ((k < 3) ? 32'h5 : 32'h1));
      check($sformatf("ld_addr0_%0d", k), addr_of(0), 32'(k));
      check($sformatf("ld_din0_%0d", k), din_of(0), 32'h1000 + 32'(k));
    end
    idle();
    tick();
    check("ld_idle_ena", 32'(bram_ena), 32'h0);
    check("ld_hold_addr0", addr_of(0), 32'd3);
    check("ld_hold_addr1", addr_of(1), 32'd1);
    check("ld_hold_addr2", addr_of(2), 32'd2);

    host_load_done = 3'b011;
    tick();
    check("ld_part_status", status, 32'h0000_0003);
    host_load_done = 3'b111;
    tick();
    check("ld_all_ch", 32'(ch_loaded), 32'h7);
    check("ld_all_early", 32'(all_loaded), 32'h0);
    check("ld_start_early", 32'(gat_start), 32'h0);
    tick();
    check("ld_start", 32'(gat_start), 32'h1);
    check("ld_status", status, 32'h8000_0007);
    tick();
    check("ld_start_once", 32'(gat_start), 32'h0);
    check("ld_all_hold", 32'(all_loaded), 32'h1);

    // ---- clear, truncation, misaligned write ----
    host_load_done = '0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_status", status, 32'h0);
    wr(0, 20'h10, 32'hDEAD_BEEF);
    tick();
    check("trunc_din", din_of(0), 32'h0000_BEEF);
    check("trunc_addr", addr_of(0), 32'd4);
    check("trunc_ena", 32'(bram_ena), 32'h1);
    idle();
    wr(1, 20'h6, 32'h5555_5555);
    tick();
    check("mis_ena", 32'(bram_ena), 32'h0);
    check("mis_status", status, 32'h0000_0200);
    check("mis_hold_addr1", addr_of(1), 32'd1);
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mis_clr_status", status, 32'h0);

    // ---- count error, overflow, same-cycle write + done ----
    set_exp(0, 19'd1); set_exp(1, 19'd1); set_exp(2, 19'd4);
    wr(1, 20'h6, 32'h1); wr(2, 20'h0, 32'hA0);
    tick();
    check("err_a_ena", 32'(bram_ena), 32'h4);
    check("err_a_status", status, 32'h0000_0200);
    wr(1, 20'h4, 32'h2); wr(2, 20'h4, 32'hA1);
    tick();
    check("err_b_ena", 32'(bram_ena), 32'h6);
    idle();
    wr(2, 20'h8, 32'hA2);
    tick();
    idle();
    host_load_done = 3'b110;
    tick();
    check("err_cnt_loaded", 32'(ch_loaded), 32'h6);
    check("err_cnt_status", status, 32'h0004_0206);
    wr(2, 20'hC, 32'hA3);
    tick();
    check("ovf_ena", 32'(bram_ena), 32'h0);
    check("ovf_status", status, 32'h0404_0206);
    idle();
    wr(0, 20'h0, 32'h77);
    host_load_done = 3'b111;
    tick();
    idle();
    check("same_ena", 32'(bram_ena), 32'h1);
    check("same_din", din_of(0), 32'h77);
    check("same_status", status, 32'h0404_0207);
    tick();
    check("same_start", 32'(gat_start), 32'h1);
    check("same_status2", status, 32'h8404_0207);
    tick();
    check("same_start_once", 32'(gat_start), 32'h0);

    // ---- clear during write / done edge, then reset mid-load ----
    host_load_done = '0;
    tick();
    clear = 1'b1;
    host_load_done = 3'b100;
    wr(0, 20'h20, 32'h99);
    tick();
    clear = 1'b0;
    idle();
    check("cw_ena", 32'(bram_ena), 32'h0);
    check("cw_status", status, 32'h0);
    check("cw_din_hold", din_of(0), 32'h77);
    check("cw_start", 32'(gat_start), 32'h0);
    tick();
    check("cw_no_edge", 32'(ch_loaded), 32'h0);
    host_load_done = '0;
    set_exp(0, 19'd1); set_exp(1, 19'd1); set_exp(2, 19'd1);
    wr(0, 20'h0, 32'h11);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_ena", 32'(bram_ena), 32'h0);
    check("mr_addr", 32'(bram_addra), 32'h0);
    check("mr_din", 32'(bram_din), 32'h0);
    check("mr_status", status, 32'h0);
    wr(0, 20'h8, 32'hC0); wr(1, 20'h8, 32'hC1); wr(2, 20'h8, 32'hC2);
    tick();
    idle();
    check("rl_ena", 32'(bram_ena), 32'h7);
    check("rl_addr1", addr_of(1), 32'd2);
    check("rl_din2", din_of(2), 32'hC2);
    host_load_done = 3'b111;
    tick();
    check("rl_loaded", status, 32'h0000_0007);
    tick();
    check("rl_start", 32'(gat_start), 32'h1);
    check("rl_status", status, 32'h8000_0007);
    tick();
    check("rl_start_once", 32'(gat_start), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
